output_layer: RTL and testbench
===============================

OUTPUT_LAYER -- requirements
Module: output_layer

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 3, AXI ID width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 64, AXI data width (fixed at 64; other values unsupported).
REQ-004 SHALL have parameter C_S_AXI_BURST_LEN, default 8, maximum beats per burst.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; reset_n  in  1  async active-low reset.
REQ-006 SHALL have these control ports:
- Start  in  1  start-frame pulse.
- axi_address  in  32  frame base byte address, 8-byte aligned.
- allocated_space_per_row  in  16  byte stride between rows.
- output_layer_row_size  in  7  pixels per row, 1..64.
- output_layer_col_size  in  8  rows per frame.
REQ-007 SHALL have these stream ports:
- output_layer_data  in  8  pixel byte.
- output_layer_valid  in  1  pixel valid.
- output_layer_rdy  out  1  pixel accept.
- done  out  1  one-cycle frame-complete pulse.
- error  out  1  sticky error flag.
REQ-008 SHALL have AXI4 write-address ports M_axi_awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awlock/awcache[3:0]/awprot[2:0]/awqos[3:0]/awvalid (out) and M_axi_awready (in).
REQ-009 SHALL have AXI4 write-data and response ports M_axi_wdata[63:0]/wstrb[7:0]/wlast/wvalid (out), M_axi_wready (in), M_axi_bid/bresp[1:0]/bvalid (in), M_axi_bready (out).

Function
REQ-010 SHALL drive constant awid=0, awsize=3'b011, awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=0, awqos=0.
REQ-011 SHALL implement states IDLE, FILL, AW, W, B, DONE.
REQ-012 SHALL, in IDLE on Start=1, latch all config inputs, clear row counter and error, and enter FILL the next cycle; Start outside IDLE is ignored.
REQ-013 SHALL, on Start with row_size=0 or col_size=0, go to DONE without AXI traffic; row_size>64 SHALL set error and go to DONE.
REQ-014 SHALL assert output_layer_rdy only in FILL; a byte transfers when valid&rdy.
REQ-015 SHALL pack bytes little-endian into an 8x64-bit row buffer: byte k of the row goes to word k/8, bits [8*(k%8)+7 : 8*(k%8)].
REQ-016 SHALL, when the last byte of a row (k=row_size-1) is accepted, deassert rdy from the next cycle and enter AW.
REQ-017 SHALL in AW drive awvalid=1 with awaddr=base+row*allocated_space_per_row (32-bit wrap) and awlen=ceil(row_size/8)-1, held stable until awready; then enter W.
REQ-018 SHALL in W present buffer words in order with wvalid=1, advancing only on wready, wlast=1 on beat awlen, wstrb=8'hFF except the final beat, where only bytes holding row pixels are strobed (unused bytes are zero).
REQ-019 SHALL never assert wvalid before the AW handshake of the same burst completes.
REQ-020 SHALL in B assert bready=1; on bvalid, increment row and enter FILL, or enter DONE if row=col_size-1.
REQ-021 SHALL in DONE assert done for exactly one cycle and return to IDLE.
REQ-022 SHALL have exactly one burst outstanding at any time.

Reset
REQ-023 SHALL, on reset_n=0 (any time, including mid-burst), asynchronously force IDLE and drive rdy, done, error, awvalid, wvalid, wlast and bready to 0 and awaddr/awlen/wdata/wstrb to 0; buffer contents are don't-care.

Configuration
REQ-024 SHALL, with macro OUTPUT_LAYER_BRESP_CHECK_EN defined, set error sticky when a handshaked bresp!=2'b00 and continue the frame; without it, bresp is ignored and error is set only per REQ-013.

Verification
REQ-025 Base 0x1000, stride 64, row 49, col 5, valid always 1, awready/wready always 1 -> 5 bursts, awaddr 0x1000/0x1040/0x1080/0x10C0/0x1100, awlen 6, last wstrb 8'h01, one done pulse.
REQ-026 Row 8, col 1, bytes 0x00..0x07 -> single beat wdata 0x0706050403020100, wstrb 8'hFF, wlast 1.
REQ-027 Random valid, random awready/wready stalls (25% duty) -> every pixel is written exactly once in order; AW signals are stable while stalled; no wvalid before the AW handshake.
REQ-028 Row 0 on Start -> done one cycle later, no awvalid; row 65 -> done and error=1.
REQ-029 reset_n low during W beat 3 -> all outputs 0 immediately; a new Start after release runs a clean frame.
REQ-030 With OUTPUT_LAYER_BRESP_CHECK_EN, bresp=2'b10 on row 2 -> error=1, frame still completes with done; without the macro -> error stays 0.

Source files
------------

// File: rtl/output_layer.sv
// output_layer -- collects a frame of 8-bit pixels row by row and writes each
// row to memory as one AXI4 INCR burst of 64-bit beats.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   Start                        start-frame pulse (sampled only in IDLE)
//   axi_address                  frame base byte address (8-byte aligned)
//   allocated_space_per_row      byte stride between consecutive rows
//   output_layer_row_size        pixels per row (1..64)
//   output_layer_col_size        rows per frame
//   output_layer_data/valid/rdy  pixel stream in (transfer on valid & rdy)
//   done                         one-cycle frame-complete pulse
//   error                        sticky error (bad row size, optional bresp)
//   M_axi_aw* / M_axi_w* / M_axi_b*  AXI4 write master channels
//
// Optional feature: define OUTPUT_LAYER_BRESP_CHECK_EN to make a non-OKAY
// write response set the sticky error flag (the frame still completes).
module output_layer #(
    parameter int C_S_AXI_ID_WIDTH   = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_BURST_LEN  = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            Start,
    input  logic [31:0]                     axi_address,
    input  logic [15:0]                     allocated_space_per_row,
    input  logic [6:0]                      output_layer_row_size,
    input  logic [7:0]                      output_layer_col_size,
    input  logic [7:0]                      output_layer_data,
    input  logic                            output_layer_valid,
    output logic                            output_layer_rdy,
    output logic                            done,
    output logic                            error,
    output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
    output logic [7:0]                      M_axi_awlen,
    output logic [2:0]                      M_axi_awsize,
    output logic [1:0]                      M_axi_awburst,
    output logic                            M_axi_awlock,
    output logic [3:0]                      M_axi_awcache,
    output logic [2:0]                      M_axi_awprot,
    output logic [3:0]                      M_axi_awqos,
    output logic                            M_axi_awvalid,
    input  logic                            M_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
    output logic                            M_axi_wlast,
    output logic                            M_axi_wvalid,
    input  logic                            M_axi_wready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_bid,
    input  logic [1:0]                      M_axi_bresp,
    input  logic                            M_axi_bvalid,
    output logic                            M_axi_bready
);

    typedef enum logic [2:0] {IDLE, FILL, AW, W, B, DONE} state_t;

    state_t state_q, state_d;

    logic [6:0]  row_size_q, row_size_d;
    logic [7:0]  col_size_q, col_size_d;
    logic [31:0] base_q, base_d;
    logic [15:0] stride_q, stride_d;
    logic [7:0]  row_q, row_d;
    logic [6:0]  k_q, k_d;          // byte index within the current row
    logic [2:0]  beat_q, beat_d;    // beat index within the current burst
    logic        error_q, error_d;
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;

    // Row buffer: one 64-bit word per beat, no reset needed.
    logic [C_S_AXI_BURST_LEN-1:0][C_S_AXI_DATA_WIDTH-1:0] buf_q, buf_d;

    logic [6:0]  row_m1;
    logic [31:0] row_off;
    logic [7:0]  last_strb;
    logic [7:0]  wstrb_c;
    logic [63:0] wword;
    logic [63:0] wdata_c;

    // bid is never checked; bresp only with the response check enabled.
    logic unused_ok;
    assign unused_ok = ^{M_axi_bid, M_axi_bresp};

    assign row_m1  = row_size_q - 7'd1;
    assign row_off = 32'(row_q) * 32'(stride_q);
    // Final beat carries lanes 0..row_m1[2:0]; all higher lanes unstrobed.
    assign last_strb = 8'hFF >> (3'd7 - row_m1[2:0]);

    always_comb begin
        state_d    = state_q;
        row_size_d = row_size_q;
        col_size_d = col_size_q;
        base_d     = base_q;
        stride_d   = stride_q;
        row_d      = row_q;
        k_d        = k_q;
        beat_d     = beat_q;
        error_d    = error_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        buf_d      = buf_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    row_size_d = output_layer_row_size;
                    col_size_d = output_layer_col_size;
                    base_d     = axi_address;
                    stride_d   = allocated_space_per_row;
                    row_d      = 8'd0;
                    k_d        = 7'd0;
                    error_d    = 1'b0;
                    if (output_layer_row_size > 7'd64) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else if (output_layer_row_size == 7'd0 ||
                                 output_layer_col_size == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (output_layer_valid && rdy_q) begin
                    buf_d[k_q[5:3]][{k_q[2:0], 3'b000} +: 8] = output_layer_data;
                    if (k_q == row_m1) begin
                        awaddr_d = C_S_AXI_ADDR_WIDTH'(base_q + row_off);
                        awlen_d  = {5'd0, row_m1[5:3]};
                        state_d  = AW;
                    end else begin
                        k_d = k_q + 7'd1;
                    end
                end
            end
            AW: begin
                if (awvalid_q && M_axi_awready) begin
                    beat_d  = 3'd0;
                    state_d = W;
                end
            end
            W: begin
                if (wvalid_q && M_axi_wready) begin
                    if (beat_q == awlen_q[2:0]) state_d = B;
                    else                        beat_d  = beat_q + 3'd1;
                end
            end
            B: begin
                if (bready_q && M_axi_bvalid) begin
`ifdef OUTPUT_LAYER_BRESP_CHECK_EN
                    if (M_axi_bresp != 2'b00) error_d = 1'b1;
`endif
                    if (row_q == col_size_q - 8'd1) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 8'd1;
                        k_d     = 7'd0;
                        state_d = FILL;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered decodes of the next state.
        rdy_d     = (state_d == FILL);
        awvalid_d = (state_d == AW);
        wvalid_d  = (state_d == W);
        bready_d  = (state_d == B);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            row_size_q <= '0;
            col_size_q <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            row_q      <= '0;
            k_q        <= '0;
            beat_q     <= '0;
            error_q    <= 1'b0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
        end else begin
            state_q    <= state_d;
            row_size_q <= row_size_d;
            col_size_q <= col_size_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            row_q      <= row_d;
            k_q        <= k_d;
            beat_q     <= beat_d;
            error_q    <= error_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Write data path is gated by wvalid_q so it reads zero under reset.
    always_comb begin
        wword   = buf_q[beat_q];
        wstrb_c = 8'h00;
        if (wvalid_q) wstrb_c = (beat_q == awlen_q[2:0]) ? last_strb : 8'hFF;
        wdata_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (wstrb_c[i]) wdata_c[8*i +: 8] = wword[8*i +: 8];
        end
    end

    assign output_layer_rdy = rdy_q;
    assign done             = done_q;
    assign error            = error_q;

    assign M_axi_awid    = '0;
    assign M_axi_awaddr  = awaddr_q;
    assign M_axi_awlen   = awlen_q;
    assign M_axi_awsize  = 3'b011;
    assign M_axi_awburst = 2'b01;
    assign M_axi_awlock  = 1'b0;
    assign M_axi_awcache = 4'b0011;
    assign M_axi_awprot  = 3'b000;
    assign M_axi_awqos   = 4'b0000;
    assign M_axi_awvalid = awvalid_q;

    assign M_axi_wdata  = wdata_c;
    assign M_axi_wstrb  = wstrb_c;
    assign M_axi_wlast  = wvalid_q && (beat_q == awlen_q[2:0]);
    assign M_axi_wvalid = wvalid_q;
    assign M_axi_bready = bready_q;

endmodule

// File: tb/tb_output_layer.sv
module tb_output_layer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [31:0] axi_address;
    logic [15:0] allocated_space_per_row;
    logic [6:0]  row_size;
    logic [7:0]  col_size;
    logic [7:0]  data;
    logic        valid;
    logic        rdy, done, error;
    logic [2:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [2:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clk = ~clk;

    output_layer dut (
        .clk(clk), .reset_n(reset_n), .Start(Start),
        .axi_address(axi_address), .allocated_space_per_row(allocated_space_per_row),
        .output_layer_row_size(row_size), .output_layer_col_size(col_size),
        .output_layer_data(data), .output_layer_valid(valid), .output_layer_rdy(rdy),
        .done(done), .error(error),
        .M_axi_awid(awid), .M_axi_awaddr(awaddr), .M_axi_awlen(awlen),
        .M_axi_awsize(awsize), .M_axi_awburst(awburst), .M_axi_awlock(awlock),
        .M_axi_awcache(awcache), .M_axi_awprot(awprot), .M_axi_awqos(awqos),
        .M_axi_awvalid(awvalid), .M_axi_awready(awready),
        .M_axi_wdata(wdata), .M_axi_wstrb(wstrb), .M_axi_wlast(wlast),
        .M_axi_wvalid(wvalid), .M_axi_wready(wready),
        .M_axi_bid(bid), .M_axi_bresp(bresp), .M_axi_bvalid(bvalid), .M_axi_bready(bready)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;

    aw_t aw_q[$];
    w_t  w_q[$];
    logic [7:0] pix [0:1023];

    int n_cmp = 0, n_err = 0;
    int w_hs = 0, done_cnt = 0, awv_cnt = 0;
    int b_row = 0, bresp_err_row = -1;
    bit stall_en = 0, abort_feed = 0;
    logic aw_seen = 0, aw_pend = 0;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    aw_t ea;
    w_t  ew;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not as required", name);
    endtask

    // Monitor / scoreboard: pops expected bursts and beats on each handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            aw_seen = 0;
            aw_pend = 0;
        end else begin
            if (done) done_cnt++;
            if (awvalid) begin
                awv_cnt++;
                if (aw_pend) begin
                    chk("aw_stable_addr", awaddr, hold_addr);
                    chk("aw_stable_len", awlen, hold_len);
                end
                if (awready) begin
                    if (aw_q.size() == 0) fail_now("aw_unexpected");
                    else begin
                        ea = aw_q.pop_front();
                        chk("awaddr", awaddr, ea.addr);
                        chk("awlen", awlen, ea.len);
                    end
                    aw_seen = 1;
                    aw_pend = 0;
                end else begin
                    aw_pend   = 1;
                    hold_addr = awaddr;
                    hold_len  = awlen;
                end
            end
            if (wvalid) begin
                chk("w_after_aw", aw_seen, 1);
                if (wready) begin
                    if (w_q.size() == 0) fail_now("w_unexpected");
                    else begin
                        ew = w_q.pop_front();
                        chk("wdata", wdata, ew.data);
                        chk("wstrb", wstrb, ew.strb);
                        chk("wlast", wlast, ew.last);
                    end
                    w_hs++;
                    if (wlast) aw_seen = 0;
                end
            end
        end
    end

    // Ready generator: 25% stall duty when enabled.
    initial begin
        awready = 1;
        wready  = 1;
        forever begin
            @(posedge clk); #1;
            awready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Write-response responder.
    initial begin
        bvalid = 0;
        bresp  = 2'b00;
        bid    = '0;
        forever begin
            @(negedge clk);
            if (reset_n && wvalid && wready && wlast) begin
                int c;
                @(posedge clk); #1;
                bvalid = 1;
                bresp  = (b_row == bresp_err_row) ? 2'b10 : 2'b00;
                c = 0;
                do begin
                    @(negedge clk);
                    c++;
                end while (!bready && reset_n && c < 1000);
                if (c >= 1000) fail_now("bready_timeout");
                @(posedge clk); #1;
                bvalid = 0;
                bresp  = 2'b00;
                b_row++;
            end
        end
    end

    task automatic fill_pix(input int mul, input int add);
        for (int i = 0; i < 1024; i++) pix[i] = 8'(i * mul + add);
    endtask

    task automatic gen_expect(input logic [31:0] base, input logic [15:0] stride,
                              input int row, input int col);
        aw_t a;
        w_t  w;
        for (int r = 0; r < col; r++) begin
            a.addr = base + 32'(r) * 32'(stride);
            a.len  = 8'((row + 7) / 8 - 1);
            aw_q.push_back(a);
            for (int b = 0; b <= int'(a.len); b++) begin
                w.data = '0;
                w.strb = '0;
                for (int j = 0; j < 8; j++) begin
                    if (b * 8 + j < row) begin
                        w.data[8*j +: 8] = pix[r * row + b * 8 + j];
                        w.strb[j] = 1'b1;
                    end
                end
                w.last = (b == int'(a.len));
                w_q.push_back(w);
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                               input int row, input int col);
        axi_address             = base;
        allocated_space_per_row = stride;
        row_size                = 7'(row);
        col_size                = 8'(col);
        b_row                   = 0;
        Start                   = 1;
        @(posedge clk); #1;
        Start = 0;
    endtask

    task automatic feed(input int n, input bit rnd);
        int  i = 0;
        int  guard = 0;
        bit  x;
        while (i < n && !abort_feed && guard < 20000) begin
            valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            data  = pix[i];
            @(negedge clk);
            x = valid && rdy;
            @(posedge clk); #1;
            if (x) i++;
            guard++;
        end
        valid = 0;
        if (guard >= 20000) fail_now("feed_timeout");
    endtask

    task automatic wait_done(input string name, input logic exp_err, input int d0);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 20000);
        chk({name, "_done"}, done, 1);
        chk({name, "_error"}, error, exp_err);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, done, 0);
        chk({name, "_done_count"}, done_cnt - d0, 1);
        chk({name, "_aw_left"}, aw_q.size(), 0);
        chk({name, "_w_left"}, w_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input string name, input logic [31:0] base, input logic [15:0] stride,
                             input int row, input int col, input bit rnd, input logic exp_err);
        int d0 = done_cnt;
        start_frame(base, stride, row, col);
        feed(row * col, rnd);
        wait_done(name, exp_err, d0);
    endtask

    initial begin
        aw_t a;
        w_t  w;
        int  d0, av0, c;
        logic exp_bresp_err;

        reset_n = 0; Start = 0; valid = 0; data = 0;
        axi_address = 0; allocated_space_per_row = 0; row_size = 0; col_size = 0;
        #1;
        chk("reset_ctrl", {rdy, done, error, awvalid, wvalid, wlast, bready}, 0);
        chk("reset_data", {awaddr, awlen, wstrb}, 0);
        chk("reset_wdata", wdata, 0);
        chk("aw_const", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
            {3'd0, 3'b011, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;

        // Single-beat row, bytes 0..7.
        fill_pix(1, 0);
        a.addr = 32'h2000; a.len = 8'd0; aw_q.push_back(a);
        w.data = 64'h0706050403020100; w.strb = 8'hFF; w.last = 1'b1; w_q.push_back(w);
        run_frame("row8", 32'h2000, 16'd16, 8, 1, 0, 1'b0);

        // 49-pixel rows, 5 rows: 7 beats each, final strobe 8'h01.
        fill_pix(13, 5);
        for (int r = 0; r < 5; r++) begin
            a.addr = 32'h1000 + 32'(r) * 32'h40; a.len = 8'd6; aw_q.push_back(a);
        end
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < 7; b++) begin
                w.data = '0;
                for (int j = 0; j < 8; j++)
                    if (b * 8 + j < 49) w.data[8*j +: 8] = pix[r * 49 + b * 8 + j];
                w.strb = (b == 6) ? 8'h01 : 8'hFF;
                w.last = (b == 6);
                w_q.push_back(w);
            end
        end
        run_frame("row49", 32'h1000, 16'd64, 49, 5, 0, 1'b0);

        // Random valid and ready stalls.
        stall_en = 1;
        fill_pix(37, 11);
        gen_expect(32'h3000_0008, 16'h0030, 20, 4);
        run_frame("stall", 32'h3000_0008, 16'h0030, 20, 4, 1, 1'b0);

        // Address wraps past 2^32.
        fill_pix(5, 200);
        gen_expect(32'hFFFF_FFC0, 16'h0040, 9, 3);
        run_frame("wrap", 32'hFFFF_FFC0, 16'h0040, 9, 3, 1, 1'b0);
        stall_en = 0;

        // Zero-size frames: done one cycle after Start, no AXI traffic.
        av0 = awv_cnt;
        start_frame(32'h5000, 16'd8, 0, 3);
        chk("row0_done", done, 1);
        chk("row0_error", error, 0);
        @(posedge clk); #1;
        chk("row0_done_low", done, 0);
        start_frame(32'h5000, 16'd8, 5, 0);
        chk("col0_done", done, 1);
        @(posedge clk); #1;
        chk("zero_no_aw", awv_cnt, av0);

        // Oversized row flags an error.
        start_frame(32'h5000, 16'd8, 65, 2);
        chk("row65_done", done, 1);
        chk("row65_error", error, 1);
        @(posedge clk); #1;
        chk("row65_no_aw", awv_cnt, av0);

        // Error response on row 2.
`ifdef OUTPUT_LAYER_BRESP_CHECK_EN
        exp_bresp_err = 1'b1;
`else
        exp_bresp_err = 1'b0;
`endif
        bresp_err_row = 2;
        fill_pix(3, 1);
        gen_expect(32'h6000, 16'd32, 16, 4);
        run_frame("bresp", 32'h6000, 16'd32, 16, 4, 0, exp_bresp_err);
        bresp_err_row = -1;

        // Reset during W beat 3 of the first burst.
        fill_pix(7, 9);
        gen_expect(32'h4000, 16'h0100, 64, 2);
        start_frame(32'h4000, 16'h0100, 64, 2);
        d0 = w_hs;
        fork
            feed(128, 0);
            begin
                c = 0;
                do begin
                    @(negedge clk); #2;
                    c++;
                end while (w_hs < d0 + 3 && c < 5000);
                if (c >= 5000) fail_now("beat3_timeout");
                chk("beat3_wvalid", wvalid, 1);
                abort_feed = 1;
                reset_n    = 0;
                #1;
                chk("midrst_ctrl", {rdy, done, error, awvalid, wvalid, wlast, bready}, 0);
                chk("midrst_data", {awaddr, awlen, wstrb}, 0);
                chk("midrst_wdata", wdata, 0);
                aw_q.delete();
                w_q.delete();
                @(posedge clk); #1;
                reset_n = 1;
            end
        join
        abort_feed = 0;
        @(posedge clk); #1;
        fill_pix(11, 4);
        gen_expect(32'h7000, 16'd16, 12, 2);
        run_frame("after_rst", 32'h7000, 16'd16, 12, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
